// File: rtl/crc_serial_check_p_if.sv
// Handshake/bus bundle for the serial CRC checker: frame control, serial data
// and frame result signals. The slave modport is the checker side.
interface crc_serial_check_p_if #(
    parameter int CRC_W = 4
) ();
    logic             en;
    logic             abort;
    logic             din;
    logic             din_valid;
    logic             ready;
    logic             done;
    logic             crc_error;
    logic [CRC_W-1:0] remainder;
    logic [15:0]      err_cnt;

    modport master (
        output en, abort, din, din_valid,
        input  ready, done, crc_error, remainder, err_cnt
    );

    modport slave (
        input  en, abort, din, din_valid,
        output ready, done, crc_error, remainder, err_cnt
    );
endinterface

// File: rtl/crc_serial_check_p.sv
// Parametrised MSB-first serial CRC checker (IDLE -> SHIFT -> DONE -> IDLE).
// Optional saturating failed-frame counter enabled by macro CRC_ERR_CNT_EN.
module crc_serial_check_p #(
    parameter int               CRC_W     = 4,
    parameter logic [CRC_W-1:0] POLY      = 4'h3,
    parameter logic [CRC_W-1:0] INIT      = 4'h0,
    parameter int               FRAME_LEN = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    crc_serial_check_p_if.slave  bus
);

    localparam int               CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CRC_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             err_set_s;

    // One serial LFSR step: feedback is the outgoing MSB xored with the new bit.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                  input logic             b);
        logic             fb;
        logic [CRC_W-1:0] shifted;
        fb      = r[CRC_W-1] ^ b;
        shifted = r << 1;
        return shifted ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

    // Next-state, datapath update and output decode.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        err_d     = err_q;
        done_d    = 1'b0;
        err_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.en) begin
                    state_d = SHIFT;
                    crc_d   = INIT;
                    cnt_d   = {CNT_W{1'b0}};
                    rem_d   = {CRC_W{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.din_valid) begin
                    crc_d = crc_step(crc_q, bus.din);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d   = DONE;
                        rem_d     = crc_d;
                        err_d     = (crc_d != {CRC_W{1'b0}});
                        err_set_s = (crc_d != {CRC_W{1'b0}});
                        done_d    = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            crc_q   <= {CRC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            rem_q   <= {CRC_W{1'b0}};
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.crc_error = err_q;
    assign bus.remainder = rem_q;

`ifdef CRC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Failed-frame counter, saturating; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= 16'h0000;
        end else if (err_set_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_crc_serial_check_p.sv
// Directed self-checking bench for crc_serial_check_p (CRC4, POLY 4'h3, 12-bit frames).
module tb_crc_serial_check_p;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] exp_err_cnt;

`ifdef CRC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    crc_serial_check_p_if #(.CRC_W(4)) bif ();

    crc_serial_check_p #(
        .CRC_W(4), .POLY(4'h3), .INIT(4'h0), .FRAME_LEN(12)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        bif.en = 1'b1;
        tick();
        bif.en = 1'b0;
    endtask

    // Sends a whole frame; returns edges from start to done and whether done was early.
    task automatic run_frame(input logic [11:0] f, input int stall_after, input int stall_len,
                             output int lat, output bit early_done);
        lat = 0;
        early_done = 1'b0;
        start_frame();
        for (int i = 0; i < 12; i++) begin
            if (i == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    bif.din_valid = 1'b0;
                    tick();
                    lat++;
                    if (bif.done) early_done = 1'b1;
                end
            end
            bif.din       = f[11-i];
            bif.din_valid = 1'b1;
            tick();
            lat++;
            if (i < 11 && bif.done) early_done = 1'b1;
        end
        bif.din_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input logic exp_err, input logic [3:0] exp_rem);
        checks++;
        if (bif.done !== 1'b1 || bif.ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b ready=%b required done=1 ready=0", name, bif.done, bif.ready);
        end
        checks++;
        if (bif.crc_error !== exp_err || bif.remainder !== exp_rem) begin
            errors++;
            $display("FAIL %s_result: crc_error=%b remainder=%h required %b %h",
                     name, bif.crc_error, bif.remainder, exp_err, exp_rem);
        end
        checks++;
        if (bif.err_cnt !== exp_err_cnt) begin
            errors++;
            $display("FAIL %s_err_cnt: %0d required %0d", name, bif.err_cnt, exp_err_cnt);
        end
        tick();
        checks++;
        if (bif.done !== 1'b0 || bif.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_post: done=%b ready=%b required done=0 ready=1", name, bif.done, bif.ready);
        end
    endtask

    task automatic check_idle_reset(input string name);
        checks++;
        if (bif.ready !== 1'b1 || bif.done !== 1'b0 || bif.crc_error !== 1'b0 ||
            bif.remainder !== 4'h0 || bif.err_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL %s: ready=%b done=%b crc_error=%b remainder=%h err_cnt=%0d required 1 0 0 0 0",
                     name, bif.ready, bif.done, bif.crc_error, bif.remainder, bif.err_cnt);
        end
    endtask

    task automatic test_reset();
        check_idle_reset("reset");
    endtask

    task automatic test_good_frame();
        int lat; bit early;
        run_frame(12'hA5B, -1, 0, lat, early);
        checks++;
        if (early || lat !== 12) begin
            errors++;
            $display("FAIL good_latency: edges=%0d early=%0b required 12 0", lat, early);
        end
        check_result("good", 1'b0, 4'h0);
    endtask

    task automatic test_bad_frame();
        int lat; bit early;
        run_frame(12'hA5A, -1, 0, lat, early);
        if (CNT_EN) exp_err_cnt = exp_err_cnt + 16'd1;
        check_result("bad", 1'b1, 4'h3);
    endtask

    task automatic test_stall();
        int lat; bit early;
        run_frame(12'hA5B, 5, 3, lat, early);
        checks++;
        if (early || lat !== 15) begin
            errors++;
            $display("FAIL stall_latency: edges=%0d early=%0b required 15 0", lat, early);
        end
        check_result("stall", 1'b0, 4'h0);
    endtask

    task automatic test_en_during_shift();
        logic [11:0] f;
        int dones;
        f = 12'hA5B;
        dones = 0;
        start_frame();
        for (int i = 0; i < 12; i++) begin
            bif.en        = (i == 3 || i == 11);
            bif.din       = f[11-i];
            bif.din_valid = 1'b1;
            tick();
            if (bif.done) dones++;
        end
        bif.en = 1'b1;
        bif.din_valid = 1'b0;
        checks++;
        if (bif.crc_error !== 1'b0 || bif.remainder !== 4'h0) begin
            errors++;
            $display("FAIL en_shift_result: crc_error=%b remainder=%h required 0 0", bif.crc_error, bif.remainder);
        end
        bif.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bif.done) dones++;
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL en_shift_dones: %0d required 1", dones);
        end
    endtask

    task automatic test_abort();
        logic [11:0] f;
        int dones;
        f = 12'hA5A;
        dones = 0;
        start_frame();
        for (int i = 0; i < 6; i++) begin
            bif.din = f[11-i];
            bif.din_valid = 1'b1;
            tick();
        end
        bif.din_valid = 1'b0;
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        checks++;
        if (bif.ready !== 1'b1 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: ready=%b done=%b required 1 0", bif.ready, bif.done);
        end
        // Remaining bits must be ignored while idle.
        for (int i = 6; i < 12; i++) begin
            bif.din = f[11-i];
            bif.din_valid = 1'b1;
            tick();
            if (bif.done) dones++;
        end
        bif.din_valid = 1'b0;
        checks++;
        if (dones !== 0 || bif.crc_error !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d crc_error=%b required 0 0", dones, bif.crc_error);
        end
        test_good_frame();
    endtask

    task automatic test_abort_last_bit();
        logic [11:0] f;
        f = 12'hA5A;
        start_frame();
        for (int i = 0; i < 12; i++) begin
            bif.din = f[11-i];
            bif.din_valid = 1'b1;
            bif.abort = (i == 11);
            tick();
        end
        bif.din_valid = 1'b0;
        bif.abort = 1'b0;
        checks++;
        if (bif.done !== 1'b0 || bif.ready !== 1'b1 || bif.crc_error !== 1'b0 ||
            bif.remainder !== 4'h0 || bif.err_cnt !== exp_err_cnt) begin
            errors++;
            $display("FAIL abort_last: done=%b ready=%b crc_error=%b remainder=%h err_cnt=%0d required 0 1 0 0 %0d",
                     bif.done, bif.ready, bif.crc_error, bif.remainder, bif.err_cnt, exp_err_cnt);
        end
    endtask

    task automatic test_abort_en_idle();
        bif.en = 1'b1;
        bif.abort = 1'b1;
        tick();
        bif.en = 1'b0;
        bif.abort = 1'b0;
        bif.din = 1'b1;
        bif.din_valid = 1'b1;
        tick();
        tick();
        bif.din_valid = 1'b0;
        checks++;
        if (bif.ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_en_idle: ready=%b required 1", bif.ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] f;
        f = 12'hA5A;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            bif.din = f[11-i];
            bif.din_valid = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_err_cnt = 16'h0000;
        check_idle_reset("reset_mid_async");
        @(negedge clk);
        bif.din_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        test_good_frame();
    endtask

    task automatic test_back_to_back();
        int lat; bit early;
        run_frame(12'hA5A, -1, 0, lat, early);
        if (CNT_EN) exp_err_cnt = exp_err_cnt + 16'd1;
        check_result("b2b_bad", 1'b1, 4'h3);
        run_frame(12'hA5B, -1, 0, lat, early);
        check_result("b2b_good", 1'b0, 4'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_err_cnt = 16'h0000;
        bif.en = 1'b0;
        bif.abort = 1'b0;
        bif.din = 1'b0;
        bif.din_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_stall();
        test_en_during_shift();
        test_abort();
        test_abort_last_bit();
        test_abort_en_idle();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
